// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg : state encoding and constants shared with the debug unit
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package imem_loader_pkg;

   localparam int          c_NB_BYTE   = 8;
   localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler : packs four bytes MSB-first into one word
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module imem_word_assembler
   import imem_loader_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = c_NB_BYTE
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_valid,
   input  logic [NB_BYTE-1:0] i_byte,
   output logic [NB_DATA-1:0] o_word,
   output logic               o_last
);

   logic [1:0]         idx_q, idx_d;
   logic [NB_DATA-1:0] word_q, word_d;

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (i_clear) begin
         idx_d  = 2'd0;
         word_d = '0;
      end else if (i_valid) begin
         word_d[NB_DATA-1-NB_BYTE*int'(idx_q) -: NB_BYTE] = i_byte;
         idx_d = idx_q + 2'd1;
      end
   end

   // o_word already contains the byte arriving this cycle, so the
   // completed word can be registered by the caller without a bubble.
   assign o_word = word_d;
   assign o_last = i_valid && !i_clear && (idx_q == 2'd3);

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         idx_q  <= 2'd0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader : UART byte stream to instruction-RAM word writer
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (byte checksum accumulator)
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int               NB_DATA   = 32,
   parameter int               NB_BYTE   = c_NB_BYTE,
   parameter int               NB_ADDR   = 8,
   parameter logic [NB_DATA-1:0] HALT_WORD = c_HALT_WORD
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_rx_valid,
   input  logic [NB_BYTE-1:0] i_rx_data,
   output logic               o_we,
   output logic [NB_ADDR-1:0] o_addr,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overflow,
   output logic [NB_ADDR-2:0] o_word_count,
   output logic [NB_BYTE-1:0] o_checksum
);

   localparam logic [NB_ADDR-1:0] c_ADDR_STEP = NB_ADDR'(4);
   localparam logic [NB_ADDR-1:0] c_ADDR_LAST = ~NB_ADDR'(3);

   loader_state_e      state_q, state_d;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic [NB_ADDR-2:0] word_count_q, word_count_d;
   logic               we_q, we_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               overflow_q, overflow_d;

   logic               asm_clear;
   logic               asm_valid;
   logic [NB_DATA-1:0] asm_word;
   logic               asm_last;

   imem_word_assembler #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_assembler (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_clear (asm_clear),
      .i_valid (asm_valid),
      .i_byte  (i_rx_data),
      .o_word  (asm_word),
      .o_last  (asm_last)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      word_count_d = word_count_q;
      we_d         = 1'b0;
      done_d       = 1'b0;
      overflow_d   = overflow_q;
      asm_clear    = 1'b0;
      asm_valid    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d      = ST_RECV;
               addr_d       = '0;
               word_count_d = '0;
               overflow_d   = 1'b0;
               asm_clear    = 1'b1;
            end
         end
         ST_RECV: begin
            asm_valid = i_rx_valid;
            if (asm_last) begin
               state_d = ST_WRITE;
               we_d    = 1'b1;
               data_d  = asm_word;
            end
         end
         ST_WRITE: begin
            word_count_d = word_count_q + (NB_ADDR-1)'(1);
            if (data_q == HALT_WORD) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (addr_q == c_ADDR_LAST) begin
               state_d    = ST_DONE;
               done_d     = 1'b1;
               overflow_d = 1'b1;
            end else begin
               // A strobe here is byte 0 of the next word.
               state_d   = ST_RECV;
               addr_d    = addr_q + c_ADDR_STEP;
               asm_valid = i_rx_valid;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         word_count_q <= '0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         word_count_q <= word_count_d;
         we_q         <= we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [NB_BYTE-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (asm_clear) begin
         checksum_d = '0;
      end else if (asm_valid) begin
         checksum_d = checksum_q + i_rx_data;
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign o_checksum = checksum_q;
`else
   assign o_checksum = '0;
`endif

   assign o_we         = we_q;
   assign o_addr       = addr_q;
   assign o_data       = data_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_overflow   = overflow_q;
   assign o_word_count = word_count_q;

endmodule

`default_nettype wire
